// File: rtl/pmp_viol_logger.sv
// pmp_viol_logger: FIFO log of PMP-denied requests, exposed as TL-UL registers with a level interrupt.
package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module pmp_viol_logger import tlul_pkg::*; #(
  parameter int Depth = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        viol_valid,
  input  logic [31:0] viol_addr,
  input  logic [2:0]  viol_type,
  input  tl_h2d_t     tl_cpu2log,
  output tl_d2h_t     tl_log2cpu,
  output logic        irq_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  logic [31:0]   addr_mem [Depth];
  logic [2:0]    type_mem [Depth];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   total_q, total_d;
  logic          ovf_q, ovf_d, irq_q;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q;
  logic [2:0]    rsp_op_q;
  logic [1:0]    rsp_size_q;
  logic [7:0]    rsp_src_q;
  logic [31:0]   rsp_data_q;
  logic [4:0]    off;
  logic          accept, is_get, is_put, rd_ok, wr_ok, pop, ctrl, flush, clr;
  logic          nonempty, do_pop, full, do_push;
  logic [31:0]   head_addr, head_info, rd_data;
  logic          unused_bits;

  assign accept    = tl_cpu2log.a_valid & ~rsp_valid_q;
  assign off       = tl_cpu2log.a_address[4:0];
  assign is_get    = tl_cpu2log.a_opcode == Get;
  assign is_put    = (tl_cpu2log.a_opcode == PutFullData) | (tl_cpu2log.a_opcode == PutPartialData);
  assign rd_ok     = is_get & ((off == 5'h00) | (off == 5'h04) | (off == 5'h0C));
  assign wr_ok     = is_put & ((off == 5'h08) | (off == 5'h10));
  assign pop       = accept & wr_ok & (off == 5'h08);
  assign ctrl      = accept & wr_ok & (off == 5'h10);
  assign flush     = ctrl & tl_cpu2log.a_data[1];
  assign clr       = ctrl & tl_cpu2log.a_data[0];
  assign nonempty  = cnt_q != '0;
  assign do_pop    = pop & nonempty;
  // A pop in the same cycle frees the slot the incoming record needs.
  assign full      = (cnt_q == CW'(Depth)) & ~do_pop;
  assign do_push   = viol_valid & ~full & ~flush;
  assign head_addr = nonempty ? addr_mem[rptr_q] : '0;
  assign head_info = {15'd0, ovf_q, 8'(cnt_q), 4'd0, nonempty, nonempty ? type_mem[rptr_q] : 3'd0};
  assign rd_data   = ~rd_ok ? '0 : (off == 5'h00) ? head_addr : (off == 5'h04) ? head_info : total_q;
  assign unused_bits = ^{tl_cpu2log.a_address[31:5], tl_cpu2log.a_data[31:2]};

  always_comb begin
    rptr_d      = flush ? '0 : rptr_q + AW'(do_pop);
    wptr_d      = flush ? '0 : wptr_q + AW'(do_push);
    cnt_d       = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    total_d     = flush ? '0 : total_q + 32'(viol_valid && (total_q != '1));
    ovf_d       = flush ? 1'b0 : (viol_valid & full) | (ovf_q & ~clr);
    rsp_valid_d = accept | (rsp_valid_q & ~tl_cpu2log.d_ready);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wptr_q] <= viol_addr;
      type_mem[wptr_q] <= viol_type;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_op_q    <= '0;
      rsp_size_q  <= '0;
      rsp_src_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      ovf_q       <= ovf_d;
      irq_q       <= (cnt_d != '0) | ovf_d;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        rsp_err_q  <= ~(rd_ok | wr_ok);
        rsp_op_q   <= is_get ? AccessAckData : AccessAck;
        rsp_size_q <= tl_cpu2log.a_size;
        rsp_src_q  <= tl_cpu2log.a_source;
        rsp_data_q <= rd_data;
      end
    end
  end

  assign irq_o      = irq_q;
  assign tl_log2cpu = '{d_valid: rsp_valid_q, d_opcode: rsp_op_q, d_size: rsp_size_q, d_source: rsp_src_q,
                        d_data: rsp_data_q, d_error: rsp_err_q, a_ready: ~rsp_valid_q};
endmodule
